branch_target_predictor: RTL and testbench

Parametrised next-generation branch predictor for the fetch stage: a tagged, direct-mapped branch target buffer plus a separately sized pattern history table of 2-bit saturating counters. It answers one fetch lookup per cycle with a registered taken/target prediction, and it learns from in-order ROB commits of B-type, JAL and JALR instructions. It sits between the fetcher/pc reg (lookup side) and the ROB (update side).

---
 rtl/branch_target_predictor_if.sv | 28 ++
 rtl/branch_target_predictor.sv | 138 +++++++++++++
 tb/tb_branch_target_predictor.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/branch_target_predictor_if.sv
// Fetch-lookup and ROB-commit signal bundle for branch_target_predictor.
// master = fetch/ROB side, slave = predictor.
interface branch_target_predictor_if;
    logic        lookup_valid;
    logic [31:0] lookup_pc;
    logic        pred_valid;
    logic        pred_hit;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        commit_valid;
    logic [31:0] commit_pc;
    logic [1:0]  commit_kind;
    logic        commit_taken;
    logic [31:0] commit_target;
    logic        commit_mispredict;

    modport master (
        output lookup_valid, lookup_pc,
        output commit_valid, commit_pc, commit_kind, commit_taken, commit_target,
        input  pred_valid, pred_hit, pred_taken, pred_target, commit_mispredict
    );

    modport slave (
        input  lookup_valid, lookup_pc,
        input  commit_valid, commit_pc, commit_kind, commit_taken, commit_target,
        output pred_valid, pred_hit, pred_taken, pred_target, commit_mispredict
    );
endinterface

// File: rtl/branch_target_predictor.sv
// Tagged direct-mapped BTB plus 2-bit PHT; one lookup and one commit per cycle.
// Optional macro BP_GSHARE_EN: PHT index XORed with a global commit history.
module branch_target_predictor #(
    parameter int BTB_IDX_W = 6,
    parameter int BTB_TAG_W = 8,
    parameter int PHT_IDX_W = 8,
    parameter int HIST_W    = 8
) (
    input  logic clk_in,
    input  logic rst_in,
    input  logic rdy_in,
    branch_target_predictor_if.slave bp
);
    localparam int BTB_N = 1 << BTB_IDX_W;
    localparam int PHT_N = 1 << PHT_IDX_W;

    typedef enum logic [1:0] {
        KIND_BRANCH = 2'b00,
        KIND_JAL    = 2'b01,
        KIND_JALR   = 2'b10,
        KIND_NONE   = 2'b11
    } kind_e;

    typedef struct packed {
        logic        hit;
        logic        taken;
        logic [31:0] target;
    } pred_t;

    logic                 r_btbValid  [BTB_N];
    logic [BTB_TAG_W-1:0] r_btbTag    [BTB_N];
    kind_e                r_btbKind   [BTB_N];
    logic [31:0]          r_btbTarget [BTB_N];
    logic [1:0]           r_pht       [PHT_N];

    logic        r_predValid;
    logic        r_predHit;
    logic        r_predTaken;
    logic [31:0] r_predTarget;
    logic        r_commitMispredict;

    logic [PHT_IDX_W-1:0] w_histMix;
`ifdef BP_GSHARE_EN
    logic [HIST_W-1:0] r_hist;
    assign w_histMix = PHT_IDX_W'(r_hist);
`else
    logic [HIST_W-1:0] w_unusedHist;
    assign w_unusedHist = '0;
    assign w_histMix    = '0;
`endif

    logic [BTB_IDX_W-1:0] w_lkIdx, w_cmIdx;
    logic [BTB_TAG_W-1:0] w_lkTag, w_cmTag;
    logic [PHT_IDX_W-1:0] w_lkPht, w_cmPht;
    pred_t                w_lkPred, w_cmPred;
    kind_e                w_cmKind;
    logic                 w_cmLive;
    logic                 w_cmMiss;
    logic                 w_unusedPcBits;

    assign w_lkIdx  = bp.lookup_pc[BTB_IDX_W+1:2];
    assign w_lkTag  = bp.lookup_pc[BTB_IDX_W+BTB_TAG_W+1:BTB_IDX_W+2];
    assign w_lkPht  = bp.lookup_pc[PHT_IDX_W+1:2] ^ w_histMix;
    assign w_cmIdx  = bp.commit_pc[BTB_IDX_W+1:2];
    assign w_cmTag  = bp.commit_pc[BTB_IDX_W+BTB_TAG_W+1:BTB_IDX_W+2];
    assign w_cmPht  = bp.commit_pc[PHT_IDX_W+1:2] ^ w_histMix;
    assign w_cmKind = kind_e'(bp.commit_kind);
    assign w_unusedPcBits = ^{bp.lookup_pc, bp.commit_pc};

    // Shared prediction rule, evaluated on pre-update table contents for both ports.
    function automatic pred_t predict(input logic [31:0] pc, input logic valid,
                                      input logic tagEq, input kind_e kind,
                                      input logic [31:0] target, input logic [1:0] ctr);
        pred_t p;
        p.hit    = valid && tagEq;
        p.taken  = p.hit && ((kind != KIND_BRANCH) || ctr[1]);
        p.target = p.taken ? target : pc + 32'd4;
        return p;
    endfunction

    assign w_lkPred = predict(bp.lookup_pc, r_btbValid[w_lkIdx], r_btbTag[w_lkIdx] == w_lkTag,
                              r_btbKind[w_lkIdx], r_btbTarget[w_lkIdx], r_pht[w_lkPht]);
    assign w_cmPred = predict(bp.commit_pc, r_btbValid[w_cmIdx], r_btbTag[w_cmIdx] == w_cmTag,
                              r_btbKind[w_cmIdx], r_btbTarget[w_cmIdx], r_pht[w_cmPht]);

    assign w_cmLive = bp.commit_valid && (w_cmKind != KIND_NONE);
    assign w_cmMiss = (w_cmPred.taken != bp.commit_taken) ||
                      (bp.commit_taken && (w_cmPred.target != bp.commit_target));

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            for (int i = 0; i < BTB_N; i++) r_btbValid[i] <= 1'b0;
            for (int i = 0; i < PHT_N; i++) r_pht[i] <= 2'b01;
`ifdef BP_GSHARE_EN
            r_hist <= '0;
`endif
            r_predValid        <= 1'b0;
            r_predHit          <= 1'b0;
            r_predTaken        <= 1'b0;
            r_predTarget       <= '0;
            r_commitMispredict <= 1'b0;
        end else if (rdy_in) begin
            r_predValid <= bp.lookup_valid;
            if (bp.lookup_valid) begin
                r_predHit    <= w_lkPred.hit;
                r_predTaken  <= w_lkPred.taken;
                r_predTarget <= w_lkPred.target;
            end
            r_commitMispredict <= w_cmLive && w_cmMiss;
            if (w_cmLive && bp.commit_taken) r_btbValid[w_cmIdx] <= 1'b1;
            // Saturating counter update; read and write share a cycle so back-to-back commits chain.
            if (w_cmLive && (w_cmKind == KIND_BRANCH)) begin
                if (bp.commit_taken && (r_pht[w_cmPht] != 2'b11))
                    r_pht[w_cmPht] <= r_pht[w_cmPht] + 2'b01;
                else if (!bp.commit_taken && (r_pht[w_cmPht] != 2'b00))
                    r_pht[w_cmPht] <= r_pht[w_cmPht] - 2'b01;
`ifdef BP_GSHARE_EN
                r_hist <= {r_hist[HIST_W-2:0], bp.commit_taken};
`endif
            end
        end
    end

    // Payload fields need no reset: they are only trusted once the valid bit is set.
    always_ff @(posedge clk_in) begin
        if (!rst_in && rdy_in && w_cmLive && bp.commit_taken) begin
            r_btbTag[w_cmIdx]    <= w_cmTag;
            r_btbKind[w_cmIdx]   <= w_cmKind;
            r_btbTarget[w_cmIdx] <= bp.commit_target;
        end
    end

    assign bp.pred_valid        = r_predValid;
    assign bp.pred_hit          = r_predHit;
    assign bp.pred_taken        = r_predTaken;
    assign bp.pred_target       = r_predTarget;
    assign bp.commit_mispredict = r_commitMispredict;
endmodule

// File: tb/tb_branch_target_predictor.sv
// Bench for branch_target_predictor: directed vector table, reset/ready sequences,
// randomized traffic against an index/tag/counter reference model, and a history-training run.
module tb_branch_target_predictor;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rdy = 1'b1;
    branch_target_predictor_if bpIf ();

    branch_target_predictor dut (
        .clk_in (clk),
        .rst_in (rst),
        .rdy_in (rdy),
        .bp     (bpIf.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          rdy;
        bit          lkValid;
        logic [31:0] lkPc;
        bit          cmValid;
        logic [1:0]  cmKind;
        bit          cmTaken;
        logic [31:0] cmPc;
        logic [31:0] cmTarget;
    } stim_t;

    typedef struct {
        stim_t       s;
        bit          expPV;
        bit          expHit;
        bit          expTaken;
        logic [31:0] expTarget;
        bit          expMis;
    } vector_t;

    int nVectors = 0;
    int nMiscompares = 0;

    // Reference model: plain arrays addressed by arithmetic on the pc.
    bit          mValid  [64];
    int unsigned mTag    [64];
    int unsigned mKind   [64];
    logic [31:0] mTarget [64];
    int          mCtr    [256];
    int unsigned mHist;
    bit          ePV, eHit, eTaken, eMis;
    logic [31:0] eTarget;

    task automatic modelReset();
        for (int i = 0; i < 64; i++) mValid[i] = 0;
        for (int i = 0; i < 256; i++) mCtr[i] = 1;
        mHist = 0;
        ePV = 0; eHit = 0; eTaken = 0; eMis = 0; eTarget = 0;
    endtask

    function automatic int unsigned phtIndex(input logic [31:0] pc);
`ifdef BP_GSHARE_EN
        return ((pc / 4) % 256) ^ mHist;
`else
        return (pc / 4) % 256;
`endif
    endfunction

    task automatic modelPredict(input logic [31:0] pc, output bit hit, output bit taken,
                                output logic [31:0] target);
        int unsigned idx = (pc / 4) % 64;
        int unsigned tag = (pc / 256) % 256;
        hit = mValid[idx] && (mTag[idx] == tag);
        if (!hit)                taken = 0;
        else if (mKind[idx] != 0) taken = 1;
        else                     taken = (mCtr[phtIndex(pc)] >= 2);
        target = taken ? mTarget[idx] : pc + 32'd4;
    endtask

    task automatic modelStep(input stim_t s);
        bit h, t;
        logic [31:0] tg;
        if (!s.rdy) return;
        ePV = s.lkValid;
        if (s.lkValid) begin
            modelPredict(s.lkPc, h, t, tg);
            eHit = h; eTaken = t; eTarget = tg;
        end
        eMis = 0;
        if (s.cmValid && s.cmKind != 3) begin
            int unsigned idx = (s.cmPc / 4) % 64;
            int unsigned p   = phtIndex(s.cmPc);
            modelPredict(s.cmPc, h, t, tg);
            eMis = (t != s.cmTaken) || (s.cmTaken && tg != s.cmTarget);
            if (s.cmTaken) begin
                mValid[idx] = 1; mTag[idx] = (s.cmPc / 256) % 256;
                mKind[idx] = s.cmKind; mTarget[idx] = s.cmTarget;
            end
            if (s.cmKind == 0) begin
                mCtr[p] = s.cmTaken ? ((mCtr[p] < 3) ? mCtr[p] + 1 : 3)
                                    : ((mCtr[p] > 0) ? mCtr[p] - 1 : 0);
                mHist = ((mHist * 2) + (s.cmTaken ? 1 : 0)) % 256;
            end
        end
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        nVectors++;
        if (actual !== expected) begin
            nMiscompares++;
            $display("[TB] FAIL %s: got 0x%08h, want 0x%08h", name, actual, expected);
        end
    endtask

    task automatic checkModel(input string tag);
        checkOutput({tag, ".pred_valid"}, 32'(bpIf.pred_valid), 32'(ePV));
        checkOutput({tag, ".pred_hit"}, 32'(bpIf.pred_hit), 32'(eHit));
        checkOutput({tag, ".pred_taken"}, 32'(bpIf.pred_taken), 32'(eTaken));
        checkOutput({tag, ".pred_target"}, bpIf.pred_target, eTarget);
        checkOutput({tag, ".mispredict"}, 32'(bpIf.commit_mispredict), 32'(eMis));
    endtask

    task automatic applyStimulus(input stim_t s);
        rdy                = s.rdy;
        bpIf.lookup_valid  = s.lkValid;
        bpIf.lookup_pc     = s.lkPc;
        bpIf.commit_valid  = s.cmValid;
        bpIf.commit_kind   = s.cmKind;
        bpIf.commit_taken  = s.cmTaken;
        bpIf.commit_pc     = s.cmPc;
        bpIf.commit_target = s.cmTarget;
        modelStep(s);
        @(posedge clk);
        #1;
    endtask

    function automatic stim_t mk(bit r, bit lv, logic [31:0] lpc, bit cv, logic [1:0] k,
                                 bit t, logic [31:0] cpc, logic [31:0] tg);
        stim_t s;
        s.rdy = r; s.lkValid = lv; s.lkPc = lpc; s.cmValid = cv;
        s.cmKind = k; s.cmTaken = t; s.cmPc = cpc; s.cmTarget = tg;
        return s;
    endfunction

    function automatic vector_t vec(stim_t s, bit pv, bit h, bit t, logic [31:0] tg, bit m);
        vector_t v;
        v.s = s; v.expPV = pv; v.expHit = h; v.expTaken = t; v.expTarget = tg; v.expMis = m;
        return v;
    endfunction

    task automatic doReset(input stim_t s);
        rst = 1'b1;
        rdy                = s.rdy;
        bpIf.lookup_valid  = s.lkValid;
        bpIf.lookup_pc     = s.lkPc;
        bpIf.commit_valid  = s.cmValid;
        bpIf.commit_kind   = s.cmKind;
        bpIf.commit_taken  = s.cmTaken;
        bpIf.commit_pc     = s.cmPc;
        bpIf.commit_target = s.cmTarget;
        modelReset();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    localparam bit [1:0] B = 2'b00, JAL = 2'b01, JALR = 2'b10, IGN = 2'b11;

    initial begin
        vector_t vecTable[$];
        stim_t   idle;
        int      lateMisses, expLateMisses;

        idle = mk(1, 0, 0, 0, B, 0, 0, 0);

        // Directed sequence; expected values assume the bimodal indexing.
        vecTable.push_back(vec(mk(1,1,32'h100, 0,B,0,0,0),              1,0,0,32'h104,0));
        vecTable.push_back(vec(mk(1,0,0, 1,B,1,32'h100,32'h80),          0,0,0,32'h104,1));
        vecTable.push_back(vec(mk(1,1,32'h100, 0,B,0,0,0),              1,1,1,32'h80,0));
        for (int i = 0; i < 3; i++)
            vecTable.push_back(vec(mk(1,0,0, 1,B,1,32'h100,32'h80),      0,1,1,32'h80,0));
        vecTable.push_back(vec(mk(1,1,32'h100, 0,B,0,0,0),              1,1,1,32'h80,0));
        vecTable.push_back(vec(mk(1,0,0, 1,B,0,32'h100,0),               0,1,1,32'h80,1));
        vecTable.push_back(vec(mk(1,0,0, 1,B,0,32'h100,0),               0,1,1,32'h80,1));
        vecTable.push_back(vec(mk(1,0,0, 1,B,0,32'h100,0),               0,1,1,32'h80,0));
        vecTable.push_back(vec(mk(1,0,0, 1,B,0,32'h100,0),               0,1,1,32'h80,0));
        vecTable.push_back(vec(mk(1,1,32'h100, 0,B,0,0,0),              1,1,0,32'h104,0));
        vecTable.push_back(vec(mk(1,1,32'h100, 1,B,0,32'h100,0),         1,1,0,32'h104,0));
        vecTable.push_back(vec(mk(1,1,32'h100, 1,B,1,32'h100,32'h80),    1,1,0,32'h104,1));
        vecTable.push_back(vec(mk(1,1,32'h100, 0,B,0,0,0),              1,1,0,32'h104,0));
        vecTable.push_back(vec(mk(1,0,0, 1,JALR,1,32'h200,32'h1234),     0,1,0,32'h104,1));
        vecTable.push_back(vec(mk(1,1,32'h200, 0,B,0,0,0),              1,1,1,32'h1234,0));
        vecTable.push_back(vec(mk(1,1,32'h300, 0,B,0,0,0),              1,0,0,32'h304,0));
        vecTable.push_back(vec(mk(1,0,0, 1,JALR,1,32'h200,32'h1234),     0,0,0,32'h304,0));
        vecTable.push_back(vec(mk(1,1,32'h300, 1,B,1,32'h300,32'h3000),  1,0,0,32'h304,1));
        vecTable.push_back(vec(mk(1,1,32'h300, 0,B,0,0,0),              1,1,1,32'h3000,0));
        vecTable.push_back(vec(mk(1,1,32'h200, 0,B,0,0,0),              1,0,0,32'h204,0));
        vecTable.push_back(vec(mk(0,1,32'h500, 1,JAL,1,32'h500,32'h40),  1,0,0,32'h204,0));
        vecTable.push_back(vec(mk(1,1,32'h500, 0,B,0,0,0),              1,0,0,32'h504,0));
        vecTable.push_back(vec(mk(1,0,0, 1,IGN,1,32'h300,32'h999),       0,0,0,32'h504,0));
        vecTable.push_back(vec(mk(1,1,32'h300, 0,B,0,0,0),              1,1,1,32'h3000,0));
        vecTable.push_back(vec(mk(1,0,0, 1,JAL,1,32'h600,32'h8),         0,1,1,32'h3000,1));
        vecTable.push_back(vec(mk(1,1,32'h600, 0,B,0,0,0),              1,1,1,32'h8,0));
        vecTable.push_back(vec(mk(1,1,32'hFFFF_FFFC, 0,B,0,0,0),        1,0,0,32'h0,0));

        doReset(idle);
        checkOutput("reset.pred_valid", 32'(bpIf.pred_valid), 0);
        checkOutput("reset.pred_hit", 32'(bpIf.pred_hit), 0);
        checkOutput("reset.pred_taken", 32'(bpIf.pred_taken), 0);
        checkOutput("reset.pred_target", bpIf.pred_target, 0);
        checkOutput("reset.mispredict", 32'(bpIf.commit_mispredict), 0);

        foreach (vecTable[i]) begin
            applyStimulus(vecTable[i].s);
`ifndef BP_GSHARE_EN
            checkOutput($sformatf("row%0d.pred_valid", i), 32'(bpIf.pred_valid), 32'(vecTable[i].expPV));
            checkOutput($sformatf("row%0d.pred_hit", i), 32'(bpIf.pred_hit), 32'(vecTable[i].expHit));
            checkOutput($sformatf("row%0d.pred_taken", i), 32'(bpIf.pred_taken), 32'(vecTable[i].expTaken));
            checkOutput($sformatf("row%0d.pred_target", i), bpIf.pred_target, vecTable[i].expTarget);
            checkOutput($sformatf("row%0d.mispredict", i), 32'(bpIf.commit_mispredict), 32'(vecTable[i].expMis));
`endif
            checkModel($sformatf("row%0d.model", i));
        end

        // Reset while not ready and with traffic in flight still clears everything.
        doReset(mk(0, 1, 32'h600, 1, JAL, 1, 32'h700, 32'h10));
        checkOutput("midreset.pred_valid", 32'(bpIf.pred_valid), 0);
        checkOutput("midreset.pred_target", bpIf.pred_target, 0);
        checkOutput("midreset.mispredict", 32'(bpIf.commit_mispredict), 0);
        applyStimulus(mk(1, 1, 32'h600, 0, B, 0, 0, 0));
        checkOutput("midreset.lookup_hit", 32'(bpIf.pred_hit), 0);
        checkOutput("midreset.lookup_target", bpIf.pred_target, 32'h604);
        applyStimulus(mk(1, 1, 32'h700, 0, B, 0, 0, 0));
        checkOutput("midreset.dropped_commit_hit", 32'(bpIf.pred_hit), 0);

        // Randomized traffic over a few indices and tags so hits, aliases and evictions occur.
        for (int n = 0; n < 400; n++) begin
            stim_t s;
            logic [31:0] pc;
            s.rdy     = ($urandom_range(0, 9) != 0);
            s.lkValid = $urandom_range(0, 2) != 0;
            pc = ($urandom_range(0, 3) << 8) | ($urandom_range(0, 7) << 2) | $urandom_range(0, 3);
            s.lkPc    = ($urandom_range(0, 49) == 0) ? 32'hFFFF_FFFC : pc;
            s.cmValid = $urandom_range(0, 1);
            s.cmKind  = 2'($urandom_range(0, 3));
            s.cmPc    = ($urandom_range(0, 3) << 8) | ($urandom_range(0, 7) << 2);
            s.cmTaken = (s.cmKind == JAL || s.cmKind == JALR) ? 1'b1 : 1'($urandom_range(0, 1));
            case ($urandom_range(0, 2))
                0:       s.cmTarget = 32'h1000;
                1:       s.cmTarget = s.cmPc ^ 32'h40;
                default: s.cmTarget = $urandom;
            endcase
            applyStimulus(s);
            checkModel($sformatf("rand%0d", n));
        end

        // Alternating branch: global history separates the two outcomes, pc-only counters cannot.
        doReset(idle);
        lateMisses = 0;
        for (int n = 0; n < 20; n++) begin
            applyStimulus(mk(1, 0, 0, 1, B, 1'(n % 2 == 0), 32'h400, 32'h4400));
            checkModel($sformatf("alt%0d", n));
            if (n >= 12 && bpIf.commit_mispredict) lateMisses++;
        end
`ifdef BP_GSHARE_EN
        expLateMisses = 0;
`else
        expLateMisses = 8;
`endif
        checkOutput("alternating.late_mispredicts", 32'(lateMisses), 32'(expLateMisses));

        applyStimulus(idle);
        $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
        $finish;
    end
endmodule
